alu32_seq_ctrl: RTL and testbench

Sequencing and arbitration controller for the shared gate-level 32-bit ALU. It accepts operation requests from two requesters over valid/ready handshakes and grants them round-robin. It drives the ALU's operand, carry-in and op-select inputs one pass at a time, chaining carry across two passes for 64-bit operations, and returns the registered result over a valid/ready response channel.

---
 rtl/alu32_seq_ctrl_pkg.sv | 35 +++
 rtl/alu32_seq_ctrl_rr_arb2.sv | 33 +++
 rtl/alu32_seq_ctrl.sv | 165 ++++++++++++++++
 tb/tb_alu32_seq_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu32_seq_ctrl_pkg.sv
// ============================================================================
// Module : alu_seq_defs (package)
// Brief  : Shared opcodes, widths and FSM state encoding for alu32_seq_ctrl.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package alu_seq_defs;

    localparam int NREQ = 2;
    localparam int W    = 32;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_NOT  = 3'd3;
    localparam logic [2:0] OP_ADD  = 3'd4;
    localparam logic [2:0] OP_SUB  = 3'd5;
    localparam logic [2:0] OP_IDLE = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_RSP  = 2'd3
    } state_t;

    // Opcodes above ADD yield zero, except SUB when subtraction is built in.
    function automatic logic op_is_zero(input logic [2:0] op, input logic sub_en);
        return (op > OP_ADD) && !(sub_en && (op == OP_SUB));
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu32_seq_ctrl_rr_arb2.sv
// ============================================================================
// Module : rr_arb2
// Brief  : Two-way round-robin arbiter; the pointer favours the requester not
//          granted last and moves only on the advance strobe.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_adv,
    input  logic       i_adv_id,
    output logic [1:0] o_gnt
);

    logic r_prio;   // 1: requester 1 has priority

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prio <= 1'b0;
        end else if (i_adv) begin
            r_prio <= ~i_adv_id;
        end
    end

    assign o_gnt[0] = i_req[0] & (~r_prio | ~i_req[1]);
    assign o_gnt[1] = i_req[1] & ( r_prio | ~i_req[0]);

endmodule

`default_nettype wire

// File: rtl/alu32_seq_ctrl.sv
// ============================================================================
// Module : alu32_seq_ctrl
// Brief  : Arbitrates two requesters onto a shared 32-bit ALU, one pass per
//          half, chaining carry for 64-bit ops. Option macro: ALU_SEQ_SUB_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module alu32_seq_ctrl
    import alu_seq_defs::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [3*NREQ-1:0]     req_op,
    input  logic [NREQ-1:0]       req_wide,
    input  logic [NREQ-1:0]       req_ci,
    input  logic [2*W*NREQ-1:0]   req_a,
    input  logic [2*W*NREQ-1:0]   req_b,
    output logic [W-1:0]          alu_in1,
    output logic [W-1:0]          alu_in2,
    output logic                  alu_ci,
    output logic [2:0]            alu_a,
    input  logic [W-1:0]          alu_out,
    input  logic                  alu_co,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [2*W-1:0]        rsp_data,
    output logic                  rsp_co
);

`ifdef ALU_SEQ_SUB_EN
    localparam logic SUB_EN = 1'b1;
`else
    localparam logic SUB_EN = 1'b0;
`endif

    state_t           r_state;
    state_t           w_next;
    logic [2:0]       r_op;
    logic             r_wide;
    logic             r_ci;
    logic             r_co;
    logic             r_id;
    logic [2*W-1:0]   r_a;
    logic [2*W-1:0]   r_b;
    logic [2*W-1:0]   r_res;

    logic [NREQ-1:0]  w_arb_req;
    logic [NREQ-1:0]  w_gnt;
    logic             w_idle;
    logic             w_take;
    logic             w_gnt_id;
    logic             w_hs;
    logic             w_is_add;
    logic             w_is_sub;
    logic             w_arith;
    logic             w_zero;
    logic             w_pass;
    logic [W-1:0]     w_a_half;
    logic [W-1:0]     w_b_half;

    assign w_idle    = (r_state == S_IDLE);
    assign w_arb_req = req_valid & {NREQ{w_idle}};
    assign w_take    = |w_gnt;
    assign w_gnt_id  = w_gnt[1];
    assign w_hs      = (r_state == S_RSP) && rsp_ready;
    assign req_ready = w_gnt;

    rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .i_req    (w_arb_req),
        .i_adv    (w_hs),
        .i_adv_id (r_id),
        .o_gnt    (w_gnt)
    );

    assign w_is_add = (r_op == OP_ADD);
    assign w_is_sub = SUB_EN && (r_op == OP_SUB);
    assign w_arith  = w_is_add | w_is_sub;
    assign w_zero   = op_is_zero(r_op, SUB_EN);
    assign w_pass   = (r_state == S_LO) || (r_state == S_HI);
    assign w_a_half = (r_state == S_HI) ? r_a[2*W-1:W] : r_a[W-1:0];
    assign w_b_half = (r_state == S_HI) ? r_b[2*W-1:W] : r_b[W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_take) w_next = S_LO;
            S_LO:    w_next = r_wide ? S_HI : S_RSP;
            S_HI:    w_next = S_RSP;
            S_RSP:   if (rsp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Subtraction is A + ~B + 1: the LO pass injects the +1, HI chains carry.
    always_comb begin
        alu_a   = OP_IDLE;
        alu_in1 = '0;
        alu_in2 = '0;
        alu_ci  = 1'b0;
        if (w_pass) begin
            alu_a   = w_is_sub ? OP_ADD : r_op;
            alu_in1 = w_a_half;
            alu_in2 = w_is_sub ? ~w_b_half : w_b_half;
            if (r_state == S_LO) begin
                alu_ci = w_is_add ? r_ci : w_is_sub;
            end else begin
                alu_ci = w_arith & r_co;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op   <= '0;
            r_wide <= 1'b0;
            r_ci   <= 1'b0;
            r_co   <= 1'b0;
            r_id   <= 1'b0;
            r_a    <= '0;
            r_b    <= '0;
            r_res  <= '0;
        end else begin
            if (w_take) begin
                r_op   <= w_gnt_id ? req_op[5:3] : req_op[2:0];
                r_wide <= req_wide[w_gnt_id];
                r_ci   <= req_ci[w_gnt_id];
                r_a    <= w_gnt_id ? req_a[4*W-1:2*W] : req_a[2*W-1:0];
                r_b    <= w_gnt_id ? req_b[4*W-1:2*W] : req_b[2*W-1:0];
                r_id   <= w_gnt_id;
                r_res  <= '0;
                r_co   <= 1'b0;
            end
            if (r_state == S_LO) begin
                r_res[W-1:0] <= w_zero ? '0 : alu_out;
                r_co         <= alu_co;
            end
            if (r_state == S_HI) begin
                r_res[2*W-1:W] <= w_zero ? '0 : alu_out;
                r_co           <= alu_co;
            end
        end
    end

    assign rsp_valid = (r_state == S_RSP);
    assign rsp_id    = r_id;
    assign rsp_data  = r_res;
    assign rsp_co    = w_arith & r_co;

endmodule

`default_nettype wire

// File: tb/tb_alu32_seq_ctrl.sv
// ============================================================================
// Module : tb_alu32_seq_ctrl
// Brief  : Directed self-checking bench for alu32_seq_ctrl with a behavioural
//          model of the shared 32-bit ALU.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_alu32_seq_ctrl;

    logic          clk;
    logic          rst;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [5:0]    req_op;
    logic [1:0]    req_wide;
    logic [1:0]    req_ci;
    logic [127:0]  req_a;
    logic [127:0]  req_b;
    logic [31:0]   alu_in1;
    logic [31:0]   alu_in2;
    logic          alu_ci;
    logic [2:0]    alu_a;
    logic [31:0]   alu_out;
    logic          alu_co;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_id;
    logic [63:0]   rsp_data;
    logic          rsp_co;

    int n_checks = 0;
    int n_fail   = 0;

    alu32_seq_ctrl u_dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_wide  (req_wide),
        .req_ci    (req_ci),
        .req_a     (req_a),
        .req_b     (req_b),
        .alu_in1   (alu_in1),
        .alu_in2   (alu_in2),
        .alu_ci    (alu_ci),
        .alu_a     (alu_a),
        .alu_out   (alu_out),
        .alu_co    (alu_co),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_co    (rsp_co)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared gate-level ALU stand-in: ops 5..7 produce zero.
    always_comb begin
        alu_out = '0;
        alu_co  = 1'b0;
        case (alu_a)
            3'd0:    alu_out = alu_in1 & alu_in2;
            3'd1:    alu_out = alu_in1 | alu_in2;
            3'd2:    alu_out = alu_in1 ^ alu_in2;
            3'd3:    alu_out = ~alu_in1;
            3'd4:    {alu_co, alu_out} = {1'b0, alu_in1} + {1'b0, alu_in2} + {32'd0, alu_ci};
            default: alu_out = '0;
        endcase
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic set_req(input int id, input logic [2:0] op, input logic wide, input logic ci,
                           input logic [63:0] a, input logic [63:0] b);
        req_op[id*3 +: 3]  = op;
        req_wide[id]       = wide;
        req_ci[id]         = ci;
        req_a[id*64 +: 64] = a;
        req_b[id*64 +: 64] = b;
        req_valid[id]      = 1'b1;
    endtask

    // Called one cycle after the accept edge; n counts edges since acceptance.
    task automatic wait_rsp(input string tag, input int exp_lat, input logic exp_id,
                            input logic [63:0] exp_d, input logic exp_co);
        int n;
        n = 1;
        while (!rsp_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq({tag, ".lat"}, 64'(n), 64'(exp_lat));
        check_eq({tag, ".id"},  64'(rsp_id), 64'(exp_id));
        check_eq({tag, ".data"}, rsp_data, exp_d);
        check_eq({tag, ".co"},  64'(rsp_co), 64'(exp_co));
    endtask

    task automatic run_req(input string tag, input int id, input logic [2:0] op, input logic wide,
                           input logic ci, input logic [63:0] a, input logic [63:0] b,
                           input int exp_lat, input logic [63:0] exp_d, input logic exp_co);
        set_req(id, op, wide, ci, a, b);
        #1;
        check_eq({tag, ".gnt"}, 64'(req_ready), 64'(1 << id));
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
        wait_rsp(tag, exp_lat, id[0], exp_d, exp_co);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [63:0] sub_exp;
        logic        sub_co;
        logic [63:0] held;
        int          n;

        rst       = 1'b1;
        req_valid = '0;
        req_op    = '0;
        req_wide  = '0;
        req_ci    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst.rsp_valid", 64'(rsp_valid), 64'd0);
        check_eq("rst.alu_a",     64'(alu_a),     64'd5);
        check_eq("rst.req_ready", 64'(req_ready), 64'd0);
        check_eq("rst.rsp_data",  rsp_data,       64'd0);
        check_eq("rst.rsp_co",    64'(rsp_co),    64'd0);
        check_eq("rst.rsp_id",    64'(rsp_id),    64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_req("add32", 0, 3'd4, 1'b0, 1'b0, 64'h0000_0000_FFFF_FFFF, 64'd1, 2, 64'd0, 1'b1);
        run_req("add64", 1, 3'd4, 1'b1, 1'b0, 64'h0000_0000_FFFF_FFFF, 64'd1, 3,
                64'h0000_0001_0000_0000, 1'b0);

        // Both requesters hold valid: grants alternate, starting with r0.
        set_req(0, 3'd2, 1'b0, 1'b0, 64'hDEAD_0000_1234_5678, 64'h0000_0000_FFFF_0000);
        set_req(1, 3'd2, 1'b0, 1'b0, 64'h0000_0000_AAAA_AAAA, 64'h0000_0000_5555_5555);
        #1;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (req_ready == 2'b00 && n < 10) begin
                @(posedge clk); #1;
                n++;
            end
            check_eq($sformatf("rr%0d.gnt", k), 64'(req_ready), (k % 2 == 0) ? 64'd1 : 64'd2);
            @(posedge clk); #1;
            wait_rsp($sformatf("rr%0d", k), 2, k[0],
                     (k % 2 == 0) ? 64'h0000_0000_EDCB_5678 : 64'h0000_0000_FFFF_FFFF, 1'b0);
            @(posedge clk); #1;
        end
        req_valid = 2'b00;
        @(posedge clk); #1;

        // Response stall with r1 waiting: no grant until after the handshake.
        rsp_ready = 1'b0;
        set_req(0, 3'd0, 1'b0, 1'b0, 64'h0000_0000_FF00_FF00, 64'h0000_0000_0FF0_0FF0);
        #1;
        check_eq("stall.gnt0", 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        set_req(1, 3'd1, 1'b0, 1'b0, 64'h0000_0000_0000_00F0, 64'h0000_0000_0000_000F);
        wait_rsp("stall.and", 2, 1'b0, 64'h0000_0000_0F00_0F00, 1'b0);
        held = rsp_data;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check_eq($sformatf("stall%0d.valid", k), 64'(rsp_valid), 64'd1);
            check_eq($sformatf("stall%0d.data", k),  rsp_data, held);
            check_eq($sformatf("stall%0d.ready", k), 64'(req_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check_eq("stall.gnt1", 64'(req_ready), 64'd2);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        wait_rsp("stall.or", 2, 1'b1, 64'h0000_0000_0000_00FF, 1'b0);
        @(posedge clk); #1;

`ifdef ALU_SEQ_SUB_EN
        sub_exp = 64'h0000_0000_FFFF_FFFF;
        sub_co  = 1'b1;
`else
        sub_exp = 64'd0;
        sub_co  = 1'b0;
`endif
        run_req("op5", 0, 3'd5, 1'b1, 1'b0, 64'h0000_0001_0000_0000, 64'd1, 3, sub_exp, sub_co);

        // Wide ADD aborted by reset during its HI pass.
        set_req(0, 3'd4, 1'b1, 1'b0, 64'h0000_0001_8000_0000, 64'h0000_0002_8000_0000);
        #1;
        check_eq("abort.gnt", 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(posedge clk); #1;
        check_eq("hi.alu_a",   64'(alu_a),   64'd4);
        check_eq("hi.alu_in1", 64'(alu_in1), 64'd1);
        check_eq("hi.alu_in2", 64'(alu_in2), 64'd2);
        check_eq("hi.alu_ci",  64'(alu_ci),  64'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("abort.rsp_valid", 64'(rsp_valid), 64'd0);
        check_eq("abort.alu_a",     64'(alu_a),     64'd5);
        check_eq("abort.alu_in1",   64'(alu_in1),   64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        set_req(0, 3'd2, 1'b0, 1'b0, 64'h0000_0000_0000_000F, 64'h0000_0000_0000_0003);
        set_req(1, 3'd3, 1'b0, 1'b0, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000);
        #1;
        check_eq("post.gnt0", 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        wait_rsp("post.xor", 2, 1'b0, 64'h0000_0000_0000_000C, 1'b0);
        @(posedge clk); #1;
        check_eq("post.gnt1", 64'(req_ready), 64'd2);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        wait_rsp("post.not", 2, 1'b1, 64'h0000_0000_FFFF_FFFF, 1'b0);
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
